// File: rtl/adr_dec_pkg.sv
// Shared types and constants for the local-bus address decoder (adr_dec_gen).
// Region constants are the decoded field values (address bits [19:4]) of each register block.
package adr_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        RECOV = 2'd2
    } state_e;

    function automatic int dec_w(input int hi, input int lo);
        return hi - lo + 1;
    endfunction

    localparam logic [15:0] DATA_OUT    = 16'hE020;
    localparam logic [15:0] DAC_CTRL    = 16'hE030;
    localparam logic [15:0] SEL_REG     = 16'hE010;
    localparam logic [15:0] CTRL_REG    = 16'h1360;
    localparam logic [15:0] DATA_IN     = 16'hE040;
    localparam logic [15:0] DATA_IN_ADC = 16'hE050;

    // Channel 0 sits in the low slice.
    localparam logic [63:0] DEF_SEL_BASE = {CTRL_REG, SEL_REG, DAC_CTRL, DATA_OUT};

endpackage

// File: rtl/adr_dec_match.sv
// Region compare and lowest-index priority encode for adr_dec_gen.
// With ADR_MASK_EN defined, each channel compares only the bits set in its mask slice.
module adr_dec_match #(
    parameter int DEC_W   = 16,
    parameter int NUM_SEL = 4
) (
    input  logic [DEC_W-1:0]         f_i,
    input  logic [NUM_SEL*DEC_W-1:0] base_i,
`ifdef ADR_MASK_EN
    input  logic [NUM_SEL*DEC_W-1:0] mask_i,
`endif
    output logic [NUM_SEL-1:0]       hit_o,
    output logic                     nohit_o
);

    logic [NUM_SEL-1:0] eq_s;

    for (genvar g = 0; g < NUM_SEL; g++) begin : g_ch
`ifdef ADR_MASK_EN
        assign eq_s[g] = ((f_i & mask_i[g*DEC_W +: DEC_W]) ==
                          (base_i[g*DEC_W +: DEC_W] & mask_i[g*DEC_W +: DEC_W]));
`else
        assign eq_s[g] = (f_i == base_i[g*DEC_W +: DEC_W]);
`endif
    end

    // Isolating the lowest set bit keeps the result one-hot when windows overlap.
    assign hit_o   = eq_s & (~eq_s + NUM_SEL'(1'b1));
    assign nohit_o = ~(|eq_s);

endmodule

// File: rtl/adr_dec_gen.sv
// Local-bus address latch, region decoder and data-phase tracker with watchdog.
// Optional masked region compare is enabled by defining ADR_MASK_EN (adds parameter SEL_MASK).
module adr_dec_gen
    import adr_dec_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEC_LO  = 4,
    parameter int DEC_HI  = 19,
    parameter int NUM_SEL = 4,
    localparam int DEC_W  = dec_w(DEC_HI, DEC_LO),
    parameter logic [NUM_SEL*DEC_W-1:0] SEL_BASE = DEF_SEL_BASE,
`ifdef ADR_MASK_EN
    parameter logic [NUM_SEL*DEC_W-1:0] SEL_MASK = '1,
`endif
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              valid_pci,
    input  logic              a_d,
    input  logic [ADDR_W-1:0] ad_to_tuvv,
    input  logic              devsel_,
    input  logic [NUM_SEL-1:0] inhibit,
    output logic [ADDR_W-1:0] ADRESS,
    output logic [NUM_SEL-1:0] sel,
    output logic              sel_miss,
    output logic              tmo_err,
    output logic              tuvv_ready
);

    localparam int WD_W = $clog2(TMO_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TMO_CYC - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [NUM_SEL-1:0]  hit_q, hit_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                miss_q, miss_d;
    logic                tmo_q, tmo_d;
    logic                rdy_q, rdy_d;

    logic [NUM_SEL-1:0]  mhit_s;
    logic                mmiss_s;
    logic                ap_s;
    logic                rel_s;

    adr_dec_match #(
        .DEC_W   (DEC_W),
        .NUM_SEL (NUM_SEL)
    ) u_match (
        .f_i     (ad_to_tuvv[DEC_HI:DEC_LO]),
        .base_i  (SEL_BASE),
`ifdef ADR_MASK_EN
        .mask_i  (SEL_MASK),
`endif
        .hit_o   (mhit_s),
        .nohit_o (mmiss_s)
    );

    assign ap_s = valid_pci & a_d & (state_q != RECOV);

    // Only a solid 0 holds the transfer; 1, X or Z all count as released.
    always_comb begin
        case (devsel_)
            1'b0:    rel_s = 1'b0;
            default: rel_s = 1'b1;
        endcase
    end

    // Next-state and registered-output logic for the data-phase tracker.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        hit_d   = hit_q;
        wdog_d  = wdog_q;
        miss_d  = 1'b0;
        tmo_d   = 1'b0;
        rdy_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (ap_s) begin
                    state_d = DATA;
                    adr_d   = ad_to_tuvv;
                    hit_d   = mhit_s;
                    wdog_d  = '0;
                    miss_d  = mmiss_s;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (ap_s) begin
                    state_d = DATA;
                    adr_d   = ad_to_tuvv;
                    hit_d   = mhit_s;
                    wdog_d  = '0;
                    miss_d  = mmiss_s;
                end else if (rel_s && (wdog_q != '0)) begin
                    // wdog_q == 0 is the first data cycle, where the target has not yet decoded.
                    state_d = IDLE;
                    adr_d   = '0;
                    hit_d   = '0;
                end else if (wdog_q == WD_MAX) begin
                    state_d = RECOV;
                    adr_d   = '0;
                    hit_d   = '0;
                    tmo_d   = 1'b1;
                    rdy_d   = 1'b0;
                end else begin
                    wdog_d  = wdog_q + WD_W'(1'b1);
                end
            end
            RECOV: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                adr_d   = '0;
                hit_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            adr_q   <= '0;
            hit_q   <= '0;
            wdog_q  <= '0;
            miss_q  <= 1'b0;
            tmo_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            hit_q   <= hit_d;
            wdog_q  <= wdog_d;
            miss_q  <= miss_d;
            tmo_q   <= tmo_d;
            rdy_q   <= rdy_d;
        end
    end

    // Inhibit gates the select directly so an interlock acts without waiting for a clock.
    assign sel        = hit_q & ~inhibit;
    assign ADRESS     = adr_q;
    assign sel_miss   = miss_q;
    assign tmo_err    = tmo_q;
    assign tuvv_ready = rdy_q;

endmodule

// File: tb/tb_adr_dec_gen.sv
// Directed bench for adr_dec_gen: transfer-level reference model plus hand-computed expectations.
module tb_adr_dec_gen;
    import adr_dec_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        valid_pci = 1'b0;
    logic        a_d = 1'b0;
    logic [31:0] ad_to_tuvv = 32'd0;
    logic        devsel_ = 1'b1;
    logic [3:0]  inhibit = 4'b0000;
    logic [31:0] ADRESS;
    logic [3:0]  sel;
    logic        sel_miss;
    logic        tmo_err;
    logic        tuvv_ready;

    int total = 0;
    int bad   = 0;
    bit go    = 1'b0;

    adr_dec_gen #(
        .TMO_CYC  (TMO)
`ifdef ADR_MASK_EN
        , .SEL_MASK ({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFF0})
`endif
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .valid_pci  (valid_pci),
        .a_d        (a_d),
        .ad_to_tuvv (ad_to_tuvv),
        .devsel_    (devsel_),
        .inhibit    (inhibit),
        .ADRESS     (ADRESS),
        .sel        (sel),
        .sel_miss   (sel_miss),
        .tmo_err    (tmo_err),
        .tuvv_ready (tuvv_ready)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] TB_BASE [4] = '{DATA_OUT, DAC_CTRL, SEL_REG, CTRL_REG};
`ifdef ADR_MASK_EN
    localparam logic [15:0] TB_MASK [4] = '{16'hFFF0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
    localparam logic [15:0] TB_MASK [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`endif

    // Region table lookup: first table entry whose (masked) field matches, -1 if none.
    function automatic int decode(input logic [31:0] a);
        logic [15:0] f;
        f = a[19:4];
        for (int i = 0; i < 4; i++) begin
            if ((f & TB_MASK[i]) == (TB_BASE[i] & TB_MASK[i])) return i;
        end
        return -1;
    endfunction

    // Transfer model: phase 0 idle, 1 in transfer, 2 recovering; age = edges since address phase.
    int          m_ph  = 0;
    int          m_age = 0;
    int          m_idx = -1;
    logic [31:0] m_adr = 32'd0;
    logic        m_miss = 1'b0;
    logic        m_tmo  = 1'b0;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_ph <= 0; m_age <= 0; m_idx <= -1; m_adr <= 32'd0;
            m_miss <= 1'b0; m_tmo <= 1'b0;
        end else begin
            m_miss <= 1'b0;
            m_tmo  <= 1'b0;
            if (m_ph == 2) begin
                m_ph <= 0;
            end else if (valid_pci && a_d) begin
                m_ph   <= 1;
                m_age  <= 0;
                m_adr  <= ad_to_tuvv;
                m_idx  <= decode(ad_to_tuvv);
                m_miss <= (decode(ad_to_tuvv) < 0);
            end else if (m_ph == 1) begin
                m_age <= m_age + 1;
                if ((devsel_ !== 1'b0) && (m_age + 1 >= 2)) begin
                    m_ph <= 0; m_adr <= 32'd0; m_idx <= -1;
                end else if (m_age + 1 == TMO) begin
                    m_ph <= 2; m_adr <= 32'd0; m_idx <= -1; m_tmo <= 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_sel();
        logic [3:0] s;
        s = 4'b0000;
        if (m_idx >= 0) s[m_idx] = 1'b1;
        return {28'd0, s & ~inhibit};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge, half a cycle away from sampling and stimulus.
    always @(negedge clk) begin
        if (go) begin
            chk("mdl_adr",  ADRESS, m_adr);
            chk("mdl_sel",  {28'd0, sel}, exp_sel());
            chk("mdl_miss", {31'd0, sel_miss}, {31'd0, m_miss});
            chk("mdl_tmo",  {31'd0, tmo_err}, {31'd0, m_tmo});
            chk("mdl_rdy",  {31'd0, tuvv_ready}, (m_ph == 2) ? 32'd0 : 32'd1);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic v, input logic [31:0] ad, input logic ds);
        valid_pci  = v;
        a_d        = v;
        ad_to_tuvv = ad;
        devsel_    = ds;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_adr"}, ADRESS, 32'd0);
        chk({tag, "_sel"}, {28'd0, sel}, 32'd0);
        chk({tag, "_miss"}, {31'd0, sel_miss}, 32'd0);
        chk({tag, "_tmo"}, {31'd0, tmo_err}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, tuvv_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] miss_reg [2];
        miss_reg[0] = DATA_IN;
        miss_reg[1] = DATA_IN_ADC;

        nxt(); nxt();
        go = 1'b1;
        chk_reset_vals("rst");
        rst_ = 1'b1;
        nxt();

        // 1: hit channel 0, devsel_ low for three edges then released
        drv(1'b1, 32'h000E_0200, 1'b0);
        nxt();
        drv(1'b0, 32'h1234_5678, 1'b0);
        chk("t1_adr", ADRESS, 32'h000E_0200);
        chk("t1_sel", {28'd0, sel}, 32'h1);
        nxt(); nxt();
        chk("t1_hold", {28'd0, sel}, 32'h1);
        devsel_ = 1'b1;
        nxt();
        chk("t1_rel_adr", ADRESS, 32'd0);
        chk("t1_rel_sel", {28'd0, sel}, 32'd0);

        // 2: channel 3 under interlock, released mid-transfer
        inhibit = 4'b1000;
        drv(1'b1, 32'h0001_3600, 1'b0);
        nxt();
        drv(1'b0, 32'h0, 1'b0);
        chk("t2_inh", {28'd0, sel}, 32'd0);
        nxt();
        inhibit = 4'b0000;
        #1;
        chk("t2_uninh", {28'd0, sel}, 32'h8);
        devsel_ = 1'b1;
        nxt();

        // 3: no region hit -> single-cycle miss pulse, transfer still tracked
        drv(1'b1, 32'h000A_BCD0, 1'b0);
        nxt();
        drv(1'b0, 32'h0, 1'b0);
        chk("t3_miss", {31'd0, sel_miss}, 32'd1);
        chk("t3_sel", {28'd0, sel}, 32'd0);
        nxt();
        chk("t3_miss_end", {31'd0, sel_miss}, 32'd0);
        chk("t3_in_data", ADRESS, 32'h000A_BCD0);
        devsel_ = 1'b1;
        nxt();
        for (int k = 0; k < 2; k++) begin
            drv(1'b1, {12'h000, miss_reg[k], 4'h8}, 1'b1);
            nxt();
            drv(1'b0, 32'h0, 1'b1);
            chk("t3_region_miss", {31'd0, sel_miss}, 32'd1);
            nxt(); nxt();
        end

        // 4: target never releases -> watchdog fires 8 cycles after the address phase
        drv(1'b1, 32'h000E_0300, 1'b0);
        nxt();
        drv(1'b0, 32'h0, 1'b0);
        for (int k = 1; k < TMO; k++) begin
            nxt();
            chk("t4_no_tmo", {31'd0, tmo_err}, 32'd0);
            chk("t4_sel", {28'd0, sel}, 32'h2);
        end
        nxt();
        chk("t4_tmo", {31'd0, tmo_err}, 32'd1);
        chk("t4_rdy", {31'd0, tuvv_ready}, 32'd0);
        chk("t4_adr", ADRESS, 32'd0);
        drv(1'b1, 32'h000E_0200, 1'b0);
        nxt();
        drv(1'b0, 32'h0, 1'b1);
        chk("t4_recov_ign", ADRESS, 32'd0);
        chk("t4_tmo_end", {31'd0, tmo_err}, 32'd0);
        chk("t4_rdy_back", {31'd0, tuvv_ready}, 32'd1);
        nxt();

        // 5: back-to-back address phases with devsel_ released
        drv(1'b1, 32'h000E_0200, 1'b1);
        nxt();
        chk("t5_sel_a", {28'd0, sel}, 32'h1);
        drv(1'b1, 32'h000E_0300, 1'b1);
        nxt();
        drv(1'b0, 32'h0, 1'b1);
        chk("t5_sel_b", {28'd0, sel}, 32'h2);
        nxt();
        chk("t5_restart", ADRESS, 32'h000E_0300);
        nxt();
        chk("t5_rel", ADRESS, 32'd0);

        // 6: asynchronous reset mid-transfer, then masked window
        drv(1'b1, 32'h000E_0200, 1'b0);
        nxt();
        drv(1'b0, 32'h0, 1'b0);
        nxt();
        #1 rst_ = 1'b0;
        #1 chk_reset_vals("async");
        #2 rst_ = 1'b1;
        nxt();
        drv(1'b1, 32'h000E_02F0, 1'b0);
        nxt();
        drv(1'b0, 32'h0, 1'b1);
`ifdef ADR_MASK_EN
        chk("t6_mask_sel", {28'd0, sel}, 32'h1);
        chk("t6_mask_miss", {31'd0, sel_miss}, 32'd0);
`else
        chk("t6_exact_sel", {28'd0, sel}, 32'd0);
        chk("t6_exact_miss", {31'd0, sel_miss}, 32'd1);
`endif
        nxt(); nxt(); nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adr_dec_gen.md
Name: adr_dec_gen

Overview:
Parametrised successor of the local-bus address latch/decoder, sitting between the PCI target core and the register blocks (data in/out, DAC control, selection, relay, controller registers).
- Latches the address phase.
- Decodes NUM_SEL one-hot region selects from a parameter base table, with per-channel interlock inhibits.
- Tracks the data phase with a small FSM and a watchdog that recovers from a target that never releases devsel_.

Parameters:
ADDR_W, 32, width of ad_to_tuvv and ADRESS
DEC_LO, 4, low bit of decoded address field
DEC_HI, 19, high bit of decoded field; DEC_W = DEC_HI-DEC_LO+1
NUM_SEL, 4, number of select channels
SEL_BASE, {16'h1360,16'hE010,16'hE030,16'hE020}, packed NUM_SEL*DEC_W; entry i at [i*DEC_W +: DEC_W]
TMO_CYC, 255, data-phase watchdog limit in clk cycles (>=2)

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous active-low reset
valid_pci  in  1  PCI core strobe
a_d  in  1  1 = address phase
ad_to_tuvv  in  ADDR_W  multiplexed address/data from PCI core
devsel_  in  1  active-low device select; any non-0 value (1, X, Z) = released
inhibit  in  NUM_SEL  per-channel interlock; 1 forces sel[i] low
ADRESS  out  ADDR_W  latched address
sel  out  NUM_SEL  one-hot region select
sel_miss  out  1  one-cycle pulse: address phase decoded no channel
tmo_err  out  1  one-cycle pulse: watchdog expired
tuvv_ready  out  1  block accepting transfers

Behaviour:
- Reset (async, rst_=0): ADRESS=0, hit register=0, sel=0, sel_miss=0, tmo_err=0, wdog=0, state=IDLE, tuvv_ready=1.
- Address-phase event (ap) = valid_pci & a_d & (state != RECOV).
- FSM states:
  - IDLE: on ap, latch ADRESS <= ad_to_tuvv; hit <= match(ad_to_tuvv); wdog <= 0; go to DATA.
  - DATA:
    - ap has highest priority: re-latch and restart wdog; stay in DATA (back-to-back).
    - Else if devsel_ !== 0 and wdog != 0: ADRESS <= 0, hit <= 0, go to IDLE. The first DATA cycle ignores devsel_ because the target decodes one cycle late.
    - Else if wdog == TMO_CYC-1: ADRESS <= 0, hit <= 0, tmo_err = 1 for one cycle, go to RECOV.
    - Else wdog <= wdog + 1. wdog saturates and never wraps.
  - RECOV: lasts exactly one cycle; tuvv_ready = 0; ap is ignored; return to IDLE.
- Latency: ADRESS and hit are valid on the cycle after ap.
- sel = hit & ~inhibit, combinational: an inhibit change acts in the same cycle and does not disturb hit.
- match:
  - field f = addr[DEC_HI:DEC_LO]; channel i hits when f == base_i.
  - Multiple hits: the lowest index wins, so hit is always one-hot or zero.
  - No hit: sel_miss pulses on the cycle after ap; ADRESS is still latched and the FSM still enters DATA.
- Bits of ADRESS outside the decoded field are stored but never decoded.
- Reset asserted mid-transfer clears everything immediately; no pulse is emitted.

Optional Feature:
ADR_MASK_EN
- Defined: adds parameter SEL_MASK (packed, same layout as SEL_BASE, default all-ones). Channel i hits when (f & mask_i) == (base_i & mask_i), so one channel can cover a register window.
- Undefined: exact compare only; SEL_MASK does not exist.

Decomposition:
- Package adr_dec_pkg holds:
  - state enum {IDLE, DATA, RECOV}
  - DEC_W derivation function
  - codebase region constants (DATA_OUT, DATA_IN_ADC, DATA_IN, SEL_REG, DAC_CTRL, ...) used to build SEL_BASE at instantiation
- One sub-module, adr_dec_match: combinational compare and lowest-index priority encode. Inputs are f, SEL_BASE and (under the macro) SEL_MASK; outputs are the one-hot hit and a no-hit flag.

Test Plan:
1. Reset, then ap with ad=32'h000E_0200, devsel_ held 0 for 3 cycles then 1 -> next cycle ADRESS=32'h000E0200 and sel=4'b0001; sel=0 and ADRESS=0 one cycle after devsel_ rises.
2. ap ad=32'h0001_3600 with inhibit=4'b1000 -> sel=0 while inhibited; inhibit drops mid-transfer -> sel=4'b1000 in the same cycle.
3. ap ad=32'h000A_BCD0 -> sel_miss pulses for exactly 1 cycle, sel=0, FSM in DATA.
4. TMO_CYC=8, ap then devsel_ held 0 -> tmo_err pulses 8 cycles after ap; tuvv_ready=0 for 1 cycle; an ap during RECOV is ignored (ADRESS stays 0).
5. Back-to-back: ap E020 followed next cycle by ap E030 with devsel_ high -> sel goes 0001 then 0010; wdog restarts; no return to IDLE between them.
6. rst_ dropped asynchronously mid-DATA -> all outputs reach reset values without a clock edge; ADR_MASK_EN build with mask 16'hFFF0 over base E020 -> ad field E02F hits channel 0.
